// File: rtl/csr_reg_if.sv
// CSR access bus shared by the EX stage and the interrupt controller.
// Latency: reads combinational, writes commit at the next clk edge.
// Backpressure: none; every access is accepted in the cycle it is presented.
// Signals:
//   ex_we_i/ex_waddr_i/ex_wdata_i   EX-stage write port
//   ex_raddr_i/ex_rdata_o           EX-stage read port
//   int_we_i/int_waddr_i/int_wdata_i interrupt-controller write port
//   int_raddr_i/int_rdata_o         interrupt-controller read port
interface csr_reg_if;
  logic        ex_we_i;
  logic [31:0] ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic [31:0] ex_raddr_i;
  logic [31:0] ex_rdata_o;
  logic        int_we_i;
  logic [31:0] int_waddr_i;
  logic [31:0] int_wdata_i;
  logic [31:0] int_raddr_i;
  logic [31:0] int_rdata_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i, ex_raddr_i,
    input  int_we_i, int_waddr_i, int_wdata_i, int_raddr_i,
    output ex_rdata_o, int_rdata_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i, ex_raddr_i,
    output int_we_i, int_waddr_i, int_wdata_i, int_raddr_i,
    input  ex_rdata_o, int_rdata_o
  );
endinterface

// File: rtl/csr_reg.sv
// Machine-mode CSR register file with 64-bit cycle counter (optional, macro CSR_COUNTER_EN).
// Latency: reads combinational with write bypass; writes and mirror outputs update 1 cycle later.
// Backpressure: none; both ports always accepted, int port wins a same-address write collision.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   bus (slave)           EX and interrupt-controller read/write ports
//   mtvec_o, mepc_o       registered mtvec / mepc
//   mstatus_o             registered mstatus as read (MPP reads 2'b11)
//   global_int_en_o       registered mstatus.MIE
module csr_reg #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_reg_if.slave    bus,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mstatus_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mstatus_rd;
`ifdef CSR_COUNTER_EN
  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
`endif

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

  // Only implemented, software-writable CSRs with a clean upper address accept writes.
  function automatic logic writable(input logic [31:0] a);
    logic ok;
    ok = 1'b0;
    if (a[31:12] == 20'd0) begin
      case (a[11:0])
        A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE: ok = 1'b1;
`ifdef CSR_COUNTER_EN
        A_MCYCLE, A_MCYCLEH: ok = 1'b1;
`endif
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Value a register reads back as after being written with d (field masks applied).
  function automatic logic [31:0] view(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] v;
    case (a)
      A_MSTATUS:      v = (d & 32'h0000_0088) | 32'h0000_1800;
      A_MIE:          v = d & 32'h0000_0888;
      A_MTVEC, A_MEPC: v = {d[31:2], 2'b00};
      default:        v = d;
    endcase
    return v;
  endfunction

  logic ex_wv;
  logic int_wv;
  assign ex_wv  = bus.ex_we_i  & writable(bus.ex_waddr_i);
  assign int_wv = bus.int_we_i & writable(bus.int_waddr_i);

  // Per-register write select; int port checked first so it wins a collision.
  function automatic logic [32:0] wsel(input logic [11:0] a);
    logic [32:0] r;
    r = 33'd0;
    if (int_wv && bus.int_waddr_i[11:0] == a)     r = {1'b1, bus.int_wdata_i};
    else if (ex_wv && bus.ex_waddr_i[11:0] == a)  r = {1'b1, bus.ex_wdata_i};
    return r;
  endfunction

  function automatic logic [31:0] state_rd(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:12] == 20'd0) begin
      case (a[11:0])
        A_MSTATUS:  v = mstatus_rd;
        A_MIE:      v = mie_q;
        A_MTVEC:    v = mtvec_q;
        A_MSCRATCH: v = mscratch_q;
        A_MEPC:     v = mepc_q;
        A_MCAUSE:   v = mcause_q;
        A_MHARTID:  v = HART_ID;
`ifdef CSR_COUNTER_EN
        A_MCYCLE, A_CYCLE:   v = cnt_q[31:0];
        A_MCYCLEH, A_CYCLEH: v = cnt_q[63:32];
`endif
        default:    v = 32'd0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [31:0] v;
    if (int_wv && bus.int_waddr_i == a)     v = view(a[11:0], bus.int_wdata_i);
    else if (ex_wv && bus.ex_waddr_i == a)  v = view(a[11:0], bus.ex_wdata_i);
    else                                    v = state_rd(a);
    return v;
  endfunction

  always_comb begin
    bus.ex_rdata_o  = rd(bus.ex_raddr_i);
    bus.int_rdata_o = rd(bus.int_raddr_i);
  end

  logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
  always_comb begin
    w_mstatus  = wsel(A_MSTATUS);
    w_mie      = wsel(A_MIE);
    w_mtvec    = wsel(A_MTVEC);
    w_mscratch = wsel(A_MSCRATCH);
    w_mepc     = wsel(A_MEPC);
    w_mcause   = wsel(A_MCAUSE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
    end else begin
      if (w_mstatus[32]) begin
        mstatus_mie_q  <= w_mstatus[3];
        mstatus_mpie_q <= w_mstatus[7];
      end
      if (w_mie[32])      mie_q      <= view(A_MIE, w_mie[31:0]);
      if (w_mtvec[32])    mtvec_q    <= view(A_MTVEC, w_mtvec[31:0]);
      if (w_mscratch[32]) mscratch_q <= w_mscratch[31:0];
      if (w_mepc[32])     mepc_q     <= view(A_MEPC, w_mepc[31:0]);
      if (w_mcause[32])   mcause_q   <= w_mcause[31:0];
    end
  end

`ifdef CSR_COUNTER_EN
  logic [32:0] w_lo, w_hi;
  always_comb begin
    w_lo = wsel(A_MCYCLE);
    w_hi = wsel(A_MCYCLEH);
    // A written half is loaded as-is; the low half keeps counting under an mcycleh write
    // but its carry never reaches the freshly loaded high half.
    case ({w_hi[32], w_lo[32]})
      2'b11:   cnt_d = {w_hi[31:0], w_lo[31:0]};
      2'b01:   cnt_d = {cnt_q[63:32], w_lo[31:0]};
      2'b10:   cnt_d = {w_hi[31:0], cnt_q[31:0] + 32'd1};
      default: cnt_d = cnt_q + 64'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 64'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_rd;
  assign global_int_en_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_reg.sv
// Randomised scoreboard bench for csr_reg against an address-map reference model.
// Latency: expectations are queued at drive time and popped by the monitor on the falling edge.
// Backpressure: none; one expectation per driven cycle.
module tb_csr_reg;
  localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
  localparam logic [31:0] HART      = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mtvec_o, mepc_o, mstatus_o;
  logic        gie;

  csr_reg_if bus();

  csr_reg #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .mtvec_o         (mtvec_o),
    .mepc_o          (mepc_o),
    .mstatus_o       (mstatus_o),
    .global_int_en_o (gie)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] ex_rd;
    logic [31:0] int_rd;
    logic [31:0] mst;
    logic [31:0] mtv;
    logic [31:0] mep;
    logic        gie;
  } exp_t;

  exp_t        sb[$];
  int          n_run  = 0;
  int          n_fail = 0;

  // Reference model: CSR contents held as read values in an address-keyed table.
  logic [31:0] m_csr [int];
  logic [63:0] m_cnt;

  logic [31:0] pool [0:13] = '{32'h300, 32'h304, 32'h305, 32'h340, 32'h341, 32'h342,
                               32'hF14, 32'hB00, 32'hB80, 32'hC00, 32'hC80, 32'h7C0,
                               32'h0001_0300, 32'h300};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_csr.delete();
    m_csr['h300] = 32'h0000_1800;
    m_csr['h304] = 32'd0;
    m_csr['h305] = MTVEC_RST & 32'hFFFF_FFFC;
    m_csr['h340] = 32'd0;
    m_csr['h341] = 32'd0;
    m_csr['h342] = 32'd0;
    m_csr['hF14] = HART;
    m_cnt        = 64'd0;
  endfunction

  function automatic bit is_cnt(input int k);
    return (k == 'hB00 || k == 'hB80);
  endfunction

  function automatic bit m_writable(input logic [31:0] a);
    int k;
    if ((a >> 12) != 0) return 1'b0;
    k = int'(a);
`ifdef CSR_COUNTER_EN
    if (is_cnt(k)) return 1'b1;
`endif
    return (k == 'h300 || k == 'h304 || k == 'h305 || k == 'h340 || k == 'h341 || k == 'h342);
  endfunction

  function automatic logic [31:0] m_view(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h300) return (d & 32'h88) | 32'h1800;
    if (a == 32'h304) return d & 32'h888;
    if (a == 32'h305 || a == 32'h341) return d & 32'hFFFF_FFFC;
    return d;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int k;
    if ((a >> 12) != 0) return 32'd0;
    k = int'(a);
`ifdef CSR_COUNTER_EN
    if (k == 'hB00 || k == 'hC00) return m_cnt[31:0];
    if (k == 'hB80 || k == 'hC80) return m_cnt[63:32];
`endif
    if (m_csr.exists(k)) return m_csr[k];
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_byp(input logic [31:0] ra,
                                        input bit ewe, input logic [31:0] ea, input logic [31:0] ed,
                                        input bit iwe, input logic [31:0] ia, input logic [31:0] id);
    if (iwe && m_writable(ia) && ia == ra) return m_view(ia, id);
    if (ewe && m_writable(ea) && ea == ra) return m_view(ea, ed);
    return m_read(ra);
  endfunction

  task automatic cyc(input bit r,
                     input bit ewe, input logic [31:0] ea, input logic [31:0] ed, input logic [31:0] era,
                     input bit iwe, input logic [31:0] ia, input logic [31:0] id, input logic [31:0] ira);
    exp_t        e;
    logic [31:0] st;
    bit          we [2];
    logic [31:0] wa [2];
    logic [31:0] wd [2];
    bit          lw, hw;
    logic [31:0] lv, hv;
    @(posedge clk);
    #1;
    rst_n           = r;
    bus.ex_we_i     = ewe;
    bus.ex_waddr_i  = ea;
    bus.ex_wdata_i  = ed;
    bus.ex_raddr_i  = era;
    bus.int_we_i    = iwe;
    bus.int_waddr_i = ia;
    bus.int_wdata_i = id;
    bus.int_raddr_i = ira;
    st       = m_csr['h300];
    e.chk_rd = r;
    e.ex_rd  = m_byp(era, ewe, ea, ed, iwe, ia, id);
    e.int_rd = m_byp(ira, ewe, ea, ed, iwe, ia, id);
    e.mst    = st;
    e.mtv    = m_csr['h305];
    e.mep    = m_csr['h341];
    e.gie    = st[3];
    sb.push_back(e);
    if (!r) begin
      m_reset();
    end else begin
      we[0] = ewe; wa[0] = ea; wd[0] = ed;
      we[1] = iwe; wa[1] = ia; wd[1] = id;
      lw = 1'b0; hw = 1'b0; lv = 32'd0; hv = 32'd0;
      for (int p = 0; p < 2; p++) begin
        if (we[p] && m_writable(wa[p])) begin
          if (wa[p] == 32'hB00)      begin lw = 1'b1; lv = wd[p]; end
          else if (wa[p] == 32'hB80) begin hw = 1'b1; hv = wd[p]; end
          else m_csr[int'(wa[p])] = m_view(wa[p], wd[p]);
        end
      end
      if (lw && hw)  m_cnt = {hv, lv};
      else if (lw)   m_cnt = {m_cnt[63:32], lv};
      else if (hw)   m_cnt = {hv, m_cnt[31:0] + 32'd1};
      else           m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic idle(input logic [31:0] era, input logic [31:0] ira);
    cyc(1'b1, 1'b0, 32'd0, 32'd0, era, 1'b0, 32'd0, 32'd0, ira);
  endtask

  // Monitor: one expectation per driven cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_rd) begin
          check("ex_rdata", bus.ex_rdata_o, e.ex_rd);
          check("int_rdata", bus.int_rdata_o, e.int_rd);
        end
        check("mstatus_o", mstatus_o, e.mst);
        check("mtvec_o", mtvec_o, e.mtv);
        check("mepc_o", mepc_o, e.mep);
        check("global_int_en_o", {31'd0, gie}, {31'd0, e.gie});
      end
    end
  end

  initial begin
    logic [31:0] ea, ia;
    rst_n           = 1'b0;
    bus.ex_we_i     = 1'b0;
    bus.ex_waddr_i  = 32'd0;
    bus.ex_wdata_i  = 32'd0;
    bus.ex_raddr_i  = 32'd0;
    bus.int_we_i    = 1'b0;
    bus.int_waddr_i = 32'd0;
    bus.int_wdata_i = 32'd0;
    bus.int_raddr_i = 32'd0;
    m_reset();

    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    idle(32'h305, 32'h300);
    // mstatus write with bypass
    cyc(1'b1, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'h300, 1'b0, 32'd0, 32'd0, 32'h300);
    idle(32'h300, 32'h300);
    // same-address collision, int wins
    cyc(1'b1, 1'b1, 32'h341, 32'h0000_1234, 32'h341, 1'b1, 32'h341, 32'h8000_0013, 32'h341);
    idle(32'h341, 32'h341);
    // different addresses both commit
    cyc(1'b1, 1'b1, 32'h340, 32'hA5A5_A5A5, 32'h342, 1'b1, 32'h342, 32'h8000_0007, 32'h340);
    idle(32'h340, 32'h342);
    // counter load, wrap and RO shadow write
    cyc(1'b1, 1'b1, 32'hB00, 32'hFFFF_FFFE, 32'hC00, 1'b1, 32'hB80, 32'hFFFF_FFFF, 32'hC80);
    repeat (3) idle(32'hC00, 32'hC80);
    cyc(1'b1, 1'b1, 32'hC00, 32'h1234_5678, 32'hC00, 1'b1, 32'hB80, 32'h0000_0042, 32'hB00);
    repeat (2) idle(32'hC00, 32'hC80);
    // unimplemented and upper-address accesses
    cyc(1'b1, 1'b1, 32'h7C0, 32'hDEAD_BEEF, 32'h7C0, 1'b1, 32'h0001_0300, 32'hFFFF_FFFF, 32'h0001_0300);
    idle(32'hF14, 32'h300);
    cyc(1'b1, 1'b1, 32'hF14, 32'h1111_1111, 32'hF14, 1'b0, 32'd0, 32'd0, 32'h304);
    // writes during reset are discarded
    cyc(1'b1, 1'b1, 32'h305, 32'h0000_4447, 32'h305, 1'b1, 32'h304, 32'hFFFF_FFFF, 32'h304);
    cyc(1'b0, 1'b1, 32'h340, 32'h5555_5555, 32'h340, 1'b1, 32'h300, 32'h0000_00FF, 32'h300);
    idle(32'h340, 32'h305);

    for (int i = 0; i < 500; i++) begin
      ea = pool[$urandom_range(0, 13)];
      ia = ($urandom_range(0, 3) == 0) ? ea : pool[$urandom_range(0, 13)];
      cyc(($urandom_range(0, 63) != 0),
          $urandom_range(0, 1) == 1, ea, $urandom, pool[$urandom_range(0, 13)],
          $urandom_range(0, 1) == 1, ia, $urandom,
          ($urandom_range(0, 1) == 1) ? ia : pool[$urandom_range(0, 13)]);
    end

    repeat (3) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
